// File: rtl/data_mem_arbiter_if.sv
// Requester and memory-side signal bundle for the two-port data memory arbiter.
interface data_mem_arbiter_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);
  localparam int unsigned BE_WIDTH = 4;

  // requester 0 (CPU load/store) and requester 1 (loader/debug)
  logic                     req0, req1;
  logic                     we0, we1;
  logic [BE_WIDTH-1:0]      be0, be1;
  logic [ADDRESS_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0]    wd0, wd1;
  logic                     gnt0, gnt1;
  logic                     ack0, ack1;
  logic                     err0, err1;
  logic [DATA_WIDTH-1:0]    rd0, rd1;
  logic                     busy;

  // single-port word memory
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0]    mem_wd;
  logic [DATA_WIDTH-1:0]    mem_rd;

  // requesters plus the memory model
  modport master (
    output req0, req1, we0, we1, be0, be1, addr0, addr1, wd0, wd1, mem_rd,
    input  gnt0, gnt1, ack0, ack1, err0, err1, rd0, rd1, busy,
    input  mem_we, mem_a, mem_wd
  );

  // the arbiter
  modport slave (
    input  req0, req1, we0, we1, be0, be1, addr0, addr1, wd0, wd1, mem_rd,
    output gnt0, gnt1, ack0, ack1, err0, err1, rd0, rd1, busy,
    output mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin two-requester controller for a single-port word data memory.
// Serialises accesses through IDLE/RD/WR/DONE, merges sub-word stores via a
// read-modify-write, and range-checks word indices against MEM_SIZE.
module data_mem_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_SIZE      = 256
) (
  input logic              clk,
  input logic              rst,
  data_mem_arbiter_if.slave bus
);
  localparam int unsigned BE_WIDTH = 4;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                  state;
  logic                    last;       // 1: port 1 was served last
  logic                    lat_port;
  logic                    lat_we;
  logic [BE_WIDTH-1:0]     lat_be;
  logic [DATA_WIDTH-1:0]   lat_wd;

  logic                     sel_c;
  logic                     grant_c;
  logic                     we_c;
  logic [BE_WIDTH-1:0]      be_c;
  logic [ADDRESS_WIDTH-1:0] addr_c;
  logic [DATA_WIDTH-1:0]    wd_c;
  logic [ADDRESS_WIDTH-1:0] idx_c;
  logic                     oor_c;

  // byte-lane merge of store data over the old memory word
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [BE_WIDTH-1:0]   be,
                                                  input logic [DATA_WIDTH-1:0] wd,
                                                  input logic [DATA_WIDTH-1:0] old);
    logic [DATA_WIDTH-1:0] m;
    m = old;
    for (int i = 0; i < int'(BE_WIDTH); i++) begin
      if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
    end
    return m;
  endfunction

  // arbitration choice and selected command, grant pulses only in IDLE
  always_comb begin
    sel_c    = 1'b0;
    grant_c  = 1'b0;
    bus.gnt0 = 1'b0;
    bus.gnt1 = 1'b0;
    if (bus.req0 && bus.req1) sel_c = ~last;
    else                      sel_c = bus.req1;
    grant_c  = (state == IDLE) && (bus.req0 || bus.req1);
    bus.gnt0 = grant_c && !sel_c;
    bus.gnt1 = grant_c && sel_c;
    we_c     = sel_c ? bus.we1   : bus.we0;
    be_c     = sel_c ? bus.be1   : bus.be0;
    addr_c   = sel_c ? bus.addr1 : bus.addr0;
    wd_c     = sel_c ? bus.wd1   : bus.wd0;
    idx_c    = addr_c >> 2;
    oor_c    = idx_c >= ADDRESS_WIDTH'(MEM_SIZE);
  end

  // access FSM with registered handshake and memory outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      lat_port   <= 1'b0;
      lat_we     <= 1'b0;
      lat_be     <= '0;
      lat_wd     <= '0;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.err0   <= 1'b0;
      bus.err1   <= 1'b0;
      bus.rd0    <= '0;
      bus.rd1    <= '0;
      bus.busy   <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_a  <= '0;
      bus.mem_wd <= '0;
    end else begin
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.err0   <= 1'b0;
      bus.err1   <= 1'b0;
      bus.mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_c) begin
            lat_port  <= sel_c;
            lat_we    <= we_c;
            lat_be    <= be_c;
            lat_wd    <= wd_c;
            last      <= sel_c;
            bus.busy  <= 1'b1;
            bus.mem_a <= idx_c;
            if (oor_c || (we_c && (be_c == '0))) begin
              // nothing to touch in memory: complete right away
              state <= DONE;
              if (sel_c) begin
                bus.ack1 <= 1'b1;
                bus.err1 <= oor_c;
                if (!we_c) bus.rd1 <= '0;
              end else begin
                bus.ack0 <= 1'b1;
                bus.err0 <= oor_c;
                if (!we_c) bus.rd0 <= '0;
              end
            end else if (we_c && (be_c == '1)) begin
              state      <= WR;
              bus.mem_we <= 1'b1;
              bus.mem_wd <= wd_c;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (lat_we) begin
            state      <= WR;
            bus.mem_we <= 1'b1;
            bus.mem_wd <= merge(lat_be, lat_wd, bus.mem_rd);
          end else begin
            state <= DONE;
            if (lat_port) begin
              bus.ack1 <= 1'b1;
              bus.rd1  <= bus.mem_rd;
            end else begin
              bus.ack0 <= 1'b1;
              bus.rd0  <= bus.mem_rd;
            end
          end
        end
        WR: begin
          state <= DONE;
          if (lat_port) bus.ack1 <= 1'b1;
          else          bus.ack0 <= 1'b1;
        end
        DONE: begin
          state     <= IDLE;
          bus.busy  <= 1'b0;
          bus.mem_a <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: table of single transactions,
// a scoreboard of expected acks, plus reset-during-write and round-robin runs.
module tb_data_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic mem_clr;

  always #5 clk = ~clk;

  data_mem_arbiter_if bus ();

  data_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // attached memory: synchronous write, asynchronous read
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (bus.mem_we && (bus.mem_a < 32'd256)) begin
      mem[bus.mem_a[7:0]] <= bus.mem_wd;
    end
  end

  assign bus.mem_rd = (bus.mem_a < 32'd256) ? mem[bus.mem_a[7:0]] : 32'h0;

  typedef struct {
    bit          port;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    bit          port;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit port, input bit req, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (port) begin
      bus.req1 = req; bus.we1 = we; bus.be1 = be; bus.addr1 = addr; bus.wd1 = wd;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.be0 = be; bus.addr0 = addr; bus.wd0 = wd;
    end
  endtask

  // pop and compare one expectation when an ack is visible
  task automatic sample_acks(output bit seen);
    exp_t e;
    bit   p;
    seen = 1'b0;
    if (bus.ack0 && bus.ack1) chk("dual_ack", 32'(bus.ack1), 32'(1'b0));
    if (bus.ack0 || bus.ack1) begin
      seen = 1'b1;
      p    = bus.ack1;
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(1'b1), 32'(1'b0));
      end else begin
        e = sb.pop_front();
        chk("ack_port", 32'(p), 32'(e.port));
        chk("ack_err", 32'(p ? bus.err1 : bus.err0), 32'(e.err));
        if (e.chk_rd) chk("ack_rd", p ? bus.rd1 : bus.rd0, e.rd);
      end
    end
  endtask

  function automatic logic [31:0] model_merge(input logic [3:0] be, input logic [31:0] wd,
                                              input logic [31:0] old);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (wd & mask) | (old & ~mask);
  endfunction

  task automatic run_vec(input vec_t v);
    logic [31:0] idx;
    logic [31:0] new_word;
    bit          got;
    bit          seen;
    bit          do_write;
    int          lat;
    int          writes;
    idx      = v.addr >> 2;
    do_write = v.we && !v.err && (v.be != 4'h0);
    new_word = do_write ? model_merge(v.be, v.wd, ref_mem[idx[7:0]]) : 32'h0;
    @(posedge clk); #1;
    drive(v.port, 1'b1, v.we, v.be, v.addr, v.wd);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (v.port ? bus.gnt1 : bus.gnt0) begin
        got = 1'b1;
        break;
      end
    end
    chk("gnt", 32'(got), 32'(1'b1));
    if (!got) begin
      drive(v.port, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      return;
    end
    chk("busy_at_gnt", 32'(bus.busy), 32'(1'b0));
    sb.push_back('{v.port, v.err, !v.we, v.rd});
    @(posedge clk); #1;
    drive(v.port, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    lat    = 0;
    writes = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        writes++;
        chk("wr_addr", bus.mem_a, idx);
        chk("wr_data", bus.mem_wd, new_word);
      end
      sample_acks(seen);
      if (seen) begin
        lat = c;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(v.lat));
    chk("write_count", 32'(writes), 32'(do_write ? 1 : 0));
    if (do_write) ref_mem[idx[7:0]] = new_word;
    if (v.we && !v.err) chk("mem_word", mem[idx[7:0]], ref_mem[idx[7:0]]);
  endtask

  vec_t tbl[13];

  initial begin
    bit          seen;
    int          acks;
    int          grants;
    int          ack_cnt;
    int          order[$];
    bit          p;

    tbl[0]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         2, 1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344, 2, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 4'h4, 32'h0000_0012, 32'h00AA_0000, 3, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         2, 1'b0, 32'h11AA_3344};
    tbl[5]  = '{1'b0, 1'b0, 4'h0, 32'h0000_0400, 32'h0,         1, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 4'hF, 32'h0000_07FC, 32'h5555_5555, 1, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 1, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 4'h3, 32'h0000_03FC, 32'hCAFE_F00D, 3, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 32'h0000_03FF, 32'h0,         2, 1'b0, 32'h0000_F00D};
    tbl[10] = '{1'b1, 1'b1, 4'h8, 32'h0000_0013, 32'h7700_0000, 3, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 4'h0, 32'h0000_0011, 32'h0,         2, 1'b0, 32'h77AA_3344};
    tbl[12] = '{1'b1, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         1, 1'b1, 32'h0};

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst     = 1'b1;
    mem_clr = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'h0);
    chk("rst_ack", 32'({bus.ack1, bus.ack0}), 32'h0);
    chk("rst_err", 32'({bus.err1, bus.err0}), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_wd", bus.mem_wd, 32'h0);
    chk("rst_rd0", bus.rd0, 32'h0);
    chk("rst_rd1", bus.rd1, 32'h0);
    rst     = 1'b0;
    mem_clr = 1'b0;

    // single transactions
    for (int i = 0; i < 13; i++) run_vec(tbl[i]);

    // async reset in the WR cycle of a partial store
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 4'h1, 32'h0000_0010, 32'h0000_00EE);
    @(negedge clk);
    chk("rw_gnt", 32'(bus.gnt0), 32'(1'b1));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #3;
    chk("rw_in_wr", 32'(bus.mem_we), 32'(1'b1));
    rst = 1'b1;
    #1;
    chk("rw_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rw_busy", 32'(bus.busy), 32'h0);
    chk("rw_mem_a", bus.mem_a, 32'h0);
    chk("rw_mem_wd", bus.mem_wd, 32'h0);
    chk("rw_rd0", bus.rd0, 32'h0);
    chk("rw_rd1", bus.rd1, 32'h0);
    @(posedge clk); #3;
    rst = 1'b0;
    sb.delete();
    ack_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) ack_cnt++;
    end
    chk("rw_no_ack", 32'(ack_cnt), 32'h0);
    chk("rw_no_write", mem[4], ref_mem[4]);

    // both ports requesting continuously: port 0 first, then alternate
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h0000_03FC, 32'h0);
    grants = 0;
    acks   = 0;
    for (int c = 0; c < 60 && acks < 4; c++) begin
      @(negedge clk);
      if (bus.gnt0 && bus.gnt1) chk("dual_gnt", 32'(1'b1), 32'(1'b0));
      if (bus.gnt0 || bus.gnt1) begin
        p = bus.gnt1;
        order.push_back(int'(p));
        sb.push_back('{p, 1'b0, 1'b1, p ? ref_mem[255] : ref_mem[4]});
        grants++;
      end
      sample_acks(seen);
      if (seen) acks++;
      @(posedge clk); #1;
      if (grants >= 4) begin
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
    end
    chk("rr_acks", 32'(acks), 32'd4);
    chk("rr_grants", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(i % 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
